rot_sequencer: RTL
==================

# rot_sequencer

Parametrised pattern sequencer: captures a WIDTH-bit pattern and steps it through STEPS phases. Each phase outputs a rotation of the pattern by a phase-dependent amount, in a selectable direction. The last phase can optionally output the pattern's complement. It drives LED and pattern-display paths in the lab datapath and is the generalised, resettable successor of the fixed 4-bit, 4-phase counter-plus-rotator pair. It adds load, enable, direction, wrap indication and a valid flag.

## Interface
- WIDTH, 4: pattern width in bits, ≥2
- STEPS, 4: number of phases, 2..256
- STRIDE, 1: rotation increment per phase, in bits
- INV_LAST, 1: 1 = last phase outputs ~pat instead of a rotation
- PW, derived: phase width = max(1, clog2(STEPS))

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  capture din into pat; restart at phase 0
- din  in  WIDTH  pattern to capture
- en  in  1  advance phase by one
- dir  in  1  0 = rotate left (toward MSB), 1 = rotate right
- y  out  WIDTH  registered transformed pattern
- phase  out  PW  current phase, 0..STEPS-1
- wrap  out  1  one-cycle pulse after phase wraps STEPS-1 → 0
- y_valid  out  1  y holds data derived from a loaded pattern

## Operation
- Internal registers: pat[WIDTH-1:0] and phase counter. The phase counter drives the `phase` port directly.
- Priority at each edge: rst_n low > load > en > hold.
- load=1:
  - pat ← din, phase ← 0.
  - en is ignored that cycle.
  - wrap ← 0.
- load=0, en=1:
  - phase ← phase+1, or 0 if phase == STEPS-1.
  - wrap ← 1 only on the STEPS-1 → 0 transition, else 0.
- load=0, en=0: pat and phase hold; wrap ← 0.
- y is recomputed every edge from the pre-edge pat, phase and dir:
  - INV_LAST=1 and phase == STEPS-1: y ← ~pat.
  - Otherwise: y ← rot(pat, ((phase+1)·STRIDE) mod WIDTH, dir).
  - A rotation amount of 0 passes pat unchanged.
- Left rotate by 1 of {b3,b2,b1,b0} gives {b2,b1,b0,b3}. Right rotate by 1 gives {b0,b3,b2,b1}.
- The rotation-amount arithmetic must be wide enough that (STEPS·STRIDE) does not overflow before the mod is applied.
- y_valid ← 1 on the edge after the first load; stays 1 until reset.
- dir is sampled every cycle and may change mid-sequence; the change takes effect on the next y update.

## Timing
- Reset values (asynchronous, immediate on rst_n fall): pat=0, phase=0, y=0, wrap=0, y_valid=0. All outputs hold these while rst_n is low.
- First active edge after rst_n rises: y ← rot(0, STRIDE) = 0; y_valid stays 0.
- Load latency:
  - load sampled at edge N: pat and phase update at N.
  - At N+1, y shows the phase-0 transform of din and y_valid=1.
- Phase-to-y latency is 1 cycle. y at edge N+1 reflects the phase value present after edge N.
- wrap is high for exactly the one cycle following the edge on which phase went STEPS-1 → 0.
  - It is coincident with the cycle in which y is computed from phase STEPS-1.
  - It is never asserted by load.
- With en held high: phase period is STEPS cycles, and wrap occurs once per STEPS cycles.
- Reset asserted mid-sequence: everything clears immediately. The next load restarts normally.

## Test plan
- Reset: drive rst_n=0 mid-run at any clk phase → y=0, phase=0, wrap=0, y_valid=0 immediately, without waiting for a clock edge.
- Default sequence, left: defaults, load din=4'b1001, dir=0, then en=1 continuously → y from the cycle after load, one value per edge: 0011, 0110, 1100, 0110 (complement), 0011, …. wrap=1 on the cycle y=0110 (complement), once per 4 cycles.
- Right rotation: load 4'b1001, dir=1, en=1 → y sequence 1100, 0110, 0011, 0110.
- Simultaneous events:
  - load=1 with en=1 at phase 2, din=4'b0001 → phase=0 next, y=0010 the following edge, wrap=0.
  - en=0 → phase and y hold.
- Parameter sweep: WIDTH=8, STEPS=5, STRIDE=2, INV_LAST=0, load 8'h01, dir=0 → y = 04, 10, 40, 01, 04, …. Amounts are 2, 4, 6, 8 mod 8 = 0, then 10 mod 8 = 2. wrap every 5 cycles.
- Mid-run dir change and y_valid: y_valid=0 until first load, then 1 permanently. Toggle dir on phase 1 → y for that phase uses the new direction.

Source files
------------

// File: rtl/rot_sequencer.sv
// Pattern sequencer: captures a WIDTH-bit pattern and steps it through STEPS phases.
// Each phase registers a rotation of the pattern, or its complement on the last phase.
module rot_sequencer #(
    parameter int WIDTH    = 4,
    parameter int STEPS    = 4,
    parameter int STRIDE   = 1,
    parameter bit INV_LAST = 1'b1,
    localparam int PW      = (STEPS > 2) ? $clog2(STEPS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] y,
    output logic [PW-1:0]    phase,
    output logic             wrap,
    output logic             y_valid
);

    localparam logic [PW-1:0] LAST_PHASE = PW'(STEPS - 1);

    logic [WIDTH-1:0]   pat;
    logic               loaded;
    logic [WIDTH-1:0]   pat_next;
    logic [PW-1:0]      phase_next;
    logic               wrap_next;
    logic [WIDTH-1:0]   y_next;
    logic [63:0]        amt;
    logic [2*WIDTH-1:0] dbl;

    always_comb begin
        pat_next   = pat;
        phase_next = phase;
        wrap_next  = 1'b0;
        if (load) begin
            pat_next   = din;
            phase_next = '0;
        end else if (en) begin
            if (phase == LAST_PHASE) begin
                phase_next = '0;
                wrap_next  = 1'b1;
            end else begin
                phase_next = phase + 1'b1;
            end
        end
    end

    // 64-bit amount keeps (phase+1)*STRIDE exact before the modulo.
    always_comb begin
        amt = ((64'(phase) + 64'd1) * 64'(STRIDE)) % 64'(WIDTH);
        if (dir) begin
            dbl    = {pat, pat} >> amt;
            y_next = dbl[WIDTH-1:0];
        end else begin
            dbl    = {pat, pat} << amt;
            y_next = dbl[2*WIDTH-1:WIDTH];
        end
        if (INV_LAST && (phase == LAST_PHASE)) begin
            y_next = ~pat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat     <= '0;
            phase   <= '0;
            wrap    <= 1'b0;
            y       <= '0;
            loaded  <= 1'b0;
            y_valid <= 1'b0;
        end else begin
            pat     <= pat_next;
            phase   <= phase_next;
            wrap    <= wrap_next;
            y       <= y_next;
            loaded  <= loaded | load;
            y_valid <= loaded;
        end
    end

endmodule
